// File: rtl/hopfield_pkg.sv
// ---------------------------------------------------------------------------
// hopfield_pkg
// Shared definitions for the Hopfield network and its rate decoder:
//   N_NEURONS  - neuron count, used by both the network and the decoder
//   NO_WINNER  - winner_idx value reported when no neuron fired in a window
//   state_t    - decoder FSM state encoding
// ---------------------------------------------------------------------------
package hopfield_pkg;

  localparam int N_NEURONS = 7;

  localparam logic [2:0] NO_WINNER = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_ARGMAX = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/spike_edge_counter.sv
// ---------------------------------------------------------------------------
// spike_edge_counter
// Rising-edge detector plus saturating event counter for a single neuron.
// Ports:
//   clk       - clock, rising edge active
//   reset_n   - asynchronous active-low reset
//   clear     - synchronous clear of the counter (has priority over counting)
//   count_en  - when 1, a rising edge on spike increments the counter
//   spike     - held spike level from the network
//   count     - current event count, saturates at all-ones
// ---------------------------------------------------------------------------
module spike_edge_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             count_en,
  input  logic             spike,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic prev_r;
  logic event_s;
  logic sat_s;

  // An event is a 0->1 transition relative to the previous cycle's level.
  assign event_s = spike & ~prev_r;
  assign sat_s   = &count;

  // Previous spike level, tracked every cycle regardless of decoder state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= spike;
    end
  end

  // Saturating event counter with clear priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && event_s && !sat_s) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// ---------------------------------------------------------------------------
// spike_rate_decoder
// Counts rising spike edges per neuron over a fixed window, then scans the
// counts sequentially (one neuron per cycle, single comparator) to find the
// most active neuron. Ties go to the lowest index; an all-zero window
// reports NO_WINNER.
// Ports:
//   clk          - clock, rising edge active
//   reset_n      - asynchronous active-low reset
//   enable       - 1 runs back-to-back windows, 0 aborts / idles
//   spikes       - N held spike levels
//   winner_idx   - index of the winning neuron (NO_WINNER if none)
//   winner_count - spike count of the winning neuron
//   active_mask  - bit i set when neuron i reached THRESH events
//   result_valid - one-cycle pulse when the three results above update
//   busy         - 1 while a window is in progress
// ---------------------------------------------------------------------------
module spike_rate_decoder
  import hopfield_pkg::*;
#(
  parameter int N      = N_NEURONS,
  parameter int WINDOW = 64,
  parameter int CNT_W  = 8,
  parameter int THRESH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [N-1:0]     spikes,
  output logic [2:0]       winner_idx,
  output logic [CNT_W-1:0] winner_count,
  output logic [N-1:0]     active_mask,
  output logic             result_valid,
  output logic             busy
);

  localparam logic [15:0]      WIN_LAST  = 16'(WINDOW - 1);
  localparam logic [2:0]       SCAN_LAST = 3'(N - 1);
  localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);

  state_t state_r;
  state_t next_state_s;

  logic [15:0]           wcnt_r;
  logic [2:0]            scan_idx_r;
  logic [2:0]            best_idx_r;
  logic [CNT_W-1:0]      best_cnt_r;
  logic [N-1:0][CNT_W-1:0] counts_s;
  logic [CNT_W-1:0]      cur_cnt_s;
  logic [N-1:0]          mask_s;

  logic clear_s;
  logic count_en_s;
  logic scan_en_s;
  logic report_s;
  logic win_done_s;
  logic scan_done_s;

  assign win_done_s  = (wcnt_r == WIN_LAST);
  assign scan_done_s = (scan_idx_r == SCAN_LAST);

  // Per-neuron edge counters.
  for (genvar g = 0; g < N; g++) begin : g_cnt
    spike_edge_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear_s),
      .count_en (count_en_s),
      .spike    (spikes[g]),
      .count    (counts_s[g])
    );
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; dropping enable aborts COUNT/ARGMAX but lets a
  // REPORT already in progress finish.
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (enable) next_state_s = ST_COUNT;
        else        next_state_s = ST_IDLE;
      end
      ST_COUNT: begin
        if (!enable)        next_state_s = ST_IDLE;
        else if (win_done_s) next_state_s = ST_ARGMAX;
        else                next_state_s = ST_COUNT;
      end
      ST_ARGMAX: begin
        if (!enable)         next_state_s = ST_IDLE;
        else if (scan_done_s) next_state_s = ST_REPORT;
        else                 next_state_s = ST_ARGMAX;
      end
      ST_REPORT: begin
        if (enable) next_state_s = ST_COUNT;
        else        next_state_s = ST_IDLE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM output decode: counters clear on the edge that enters COUNT.
  always_comb begin
    clear_s    = 1'b0;
    count_en_s = 1'b0;
    scan_en_s  = 1'b0;
    report_s   = 1'b0;
    case (state_r)
      ST_IDLE:   clear_s    = (next_state_s == ST_COUNT);
      ST_COUNT:  count_en_s = 1'b1;
      ST_ARGMAX: scan_en_s  = 1'b1;
      ST_REPORT: begin
        report_s = 1'b1;
        clear_s  = (next_state_s == ST_COUNT);
      end
      default:   clear_s    = 1'b0;
    endcase
  end

  // Window cycle counter, 0..WINDOW-1 while counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt_r <= 16'd0;
    end else if (clear_s) begin
      wcnt_r <= 16'd0;
    end else if (count_en_s) begin
      wcnt_r <= wcnt_r + 16'd1;
    end else begin
      wcnt_r <= wcnt_r;
    end
  end

  // Select the count of the neuron currently being scanned.
  always_comb begin
    cur_cnt_s = '0;
    for (int i = 0; i < N; i++) begin
      if (scan_idx_r == 3'(i)) cur_cnt_s = counts_s[i];
      else                     cur_cnt_s = cur_cnt_s;
    end
  end

  // Threshold flags for every neuron.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < N; i++) begin
      mask_s[i] = (counts_s[i] >= THRESH_C);
    end
  end

  // Sequential argmax: strict greater-than keeps the lowest index on ties,
  // and starting from zero means an all-zero window never replaces
  // NO_WINNER.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_idx_r <= 3'd0;
      best_idx_r <= NO_WINNER;
      best_cnt_r <= '0;
    end else if (count_en_s) begin
      scan_idx_r <= 3'd0;
      best_idx_r <= NO_WINNER;
      best_cnt_r <= '0;
    end else if (scan_en_s) begin
      scan_idx_r <= scan_idx_r + 3'd1;
      if (cur_cnt_s > best_cnt_r) begin
        best_idx_r <= scan_idx_r;
        best_cnt_r <= cur_cnt_s;
      end else begin
        best_idx_r <= best_idx_r;
        best_cnt_r <= best_cnt_r;
      end
    end else begin
      scan_idx_r <= scan_idx_r;
      best_idx_r <= best_idx_r;
      best_cnt_r <= best_cnt_r;
    end
  end

  // Result registers: updated only in REPORT, held otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      winner_idx   <= NO_WINNER;
      winner_count <= '0;
      active_mask  <= '0;
      result_valid <= 1'b0;
    end else if (report_s) begin
      winner_idx   <= best_idx_r;
      winner_count <= best_cnt_r;
      active_mask  <= mask_s;
      result_valid <= 1'b1;
    end else begin
      winner_idx   <= winner_idx;
      winner_count <= winner_count;
      active_mask  <= active_mask;
      result_valid <= 1'b0;
    end
  end

  // Busy flag registered from the next state so it tracks state != IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (next_state_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// ---------------------------------------------------------------------------
// tb_spike_rate_decoder
// Two decoders share clock, reset, enable and spikes: one with default
// parameters and one with CNT_W=4 to exercise saturation. Expected results
// come from a window-level model that counts 0->1 transitions in the driven
// pattern, saturates, and picks the first strict maximum.
// ---------------------------------------------------------------------------
module tb_spike_rate_decoder;

  localparam int N      = 7;
  localparam int WINDOW = 64;
  localparam int LAT    = WINDOW + N + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         enable;
  logic [N-1:0] spikes;

  logic [2:0]   w_idx8, w_idx4;
  logic [7:0]   w_cnt8;
  logic [3:0]   w_cnt4;
  logic [N-1:0] mask8, mask4;
  logic         rv8, rv4, busy8, busy4;

  spike_rate_decoder dut (
    .clk (clk), .reset_n (reset_n), .enable (enable), .spikes (spikes),
    .winner_idx (w_idx8), .winner_count (w_cnt8), .active_mask (mask8),
    .result_valid (rv8), .busy (busy8)
  );

  spike_rate_decoder #(.CNT_W (4)) dut4 (
    .clk (clk), .reset_n (reset_n), .enable (enable), .spikes (spikes),
    .winner_idx (w_idx4), .winner_count (w_cnt4), .active_mask (mask4),
    .result_valid (rv4), .busy (busy4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0] win_pat [WINDOW];
  logic [N-1:0] last_sp;
  int h_idx8, h_cnt8, h_mask8, h_idx4, h_cnt4, h_mask4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v);
    spikes  = v;
    last_sp = v;
  endtask

  // Window-level reference: events are 0->1 transitions over the pattern.
  task automatic model(input logic [N-1:0] prev0, input int cmax,
                       output int idx, output int cnt, output int mask);
    int c [N];
    logic [N-1:0] p;
    p = prev0;
    for (int i = 0; i < N; i++) c[i] = 0;
    for (int t = 0; t < WINDOW; t++) begin
      for (int i = 0; i < N; i++) begin
        if (win_pat[t][i] && !p[i]) c[i]++;
      end
      p = win_pat[t];
    end
    idx = 7; cnt = 0; mask = 0;
    for (int i = 0; i < N; i++) begin
      if (c[i] > cmax) c[i] = cmax;
      if (c[i] >= 2) mask |= (1 << i);
      if (c[i] > cnt) begin
        cnt = c[i];
        idx = i;
      end
    end
  endtask

  task automatic check_held(input string tag);
    check({tag, "_idx8"},  32'(w_idx8), h_idx8);
    check({tag, "_cnt8"},  32'(w_cnt8), h_cnt8);
    check({tag, "_mask8"}, 32'(mask8),  h_mask8);
    check({tag, "_idx4"},  32'(w_idx4), h_idx4);
    check({tag, "_cnt4"},  32'(w_cnt4), h_cnt4);
    check({tag, "_mask4"}, 32'(mask4),  h_mask4);
  endtask

  // One full window. chain_in: already at COUNT cycle 0 (previous window
  // kept enable high). chain_out: keep enable high through REPORT.
  task automatic run_window(input bit chain_in, input bit chain_out);
    int ei8, ec8, em8, ei4, ec4, em4;
    if (!chain_in) begin
      enable = 1'b1;
      drive('0);
      tick();
    end
    check("busy_c0", 32'(busy8), 1);
    model(last_sp, 255, ei8, ec8, em8);
    model(last_sp, 15, ei4, ec4, em4);
    for (int c = 0; c < LAT; c++) begin
      enable = (c == LAT - 1) ? chain_out : 1'b1;
      if (c < WINDOW) drive(win_pat[c]);
      else            drive(N'($urandom));
      tick();
      if (c + 1 < LAT) begin
        check("rv8_early", 32'(rv8), 0);
        check("rv4_early", 32'(rv4), 0);
        if (c + 1 == 40) check_held("hold_mid");
      end
    end
    check("rv8_at_lat", 32'(rv8), 1);
    check("rv4_at_lat", 32'(rv4), 1);
    h_idx8 = ei8; h_cnt8 = ec8; h_mask8 = em8;
    h_idx4 = ei4; h_cnt4 = ec4; h_mask4 = em4;
    check_held("result");
    check("busy_after_rep", 32'(busy8), 32'(chain_out));
    if (!chain_out) begin
      enable = 1'b0;
      drive(N'($urandom));
      tick();
      check("rv8_single", 32'(rv8), 0);
      check("busy8_idle", 32'(busy8), 0);
      check("busy4_idle", 32'(busy4), 0);
      check_held("post_rep");
    end
  endtask

  // Start a window and drop enable during cycle at_c (from COUNT entry).
  task automatic abort_window(input int at_c);
    enable = 1'b1;
    drive('0);
    tick();
    check("abort_busy_c0", 32'(busy8), 1);
    for (int c = 0; c <= at_c; c++) begin
      enable = (c == at_c) ? 1'b0 : 1'b1;
      drive(N'($urandom));
      tick();
    end
    check("abort_busy8", 32'(busy8), 0);
    check("abort_busy4", 32'(busy4), 0);
    for (int c = 0; c < LAT + 8; c++) begin
      drive(N'($urandom));
      tick();
      check("abort_rv8", 32'(rv8), 0);
      check("abort_rv4", 32'(rv4), 0);
    end
    check_held("abort_hold");
  endtask

  task automatic fill_random();
    int dens [N];
    for (int i = 0; i < N; i++) dens[i] = $urandom_range(0, 8);
    for (int t = 0; t < WINDOW; t++) begin
      for (int i = 0; i < N; i++) begin
        win_pat[t][i] = ($urandom_range(0, 15) < dens[i]);
      end
    end
  endtask

  task automatic reset_values(input string tag);
    h_idx8 = 7; h_cnt8 = 0; h_mask8 = 0;
    h_idx4 = 7; h_cnt4 = 0; h_mask4 = 0;
    check_held(tag);
    check({tag, "_rv8"},   32'(rv8),   0);
    check({tag, "_rv4"},   32'(rv4),   0);
    check({tag, "_busy8"}, 32'(busy8), 0);
    check({tag, "_busy4"}, 32'(busy4), 0);
  endtask

  initial begin
    bit chain;
    reset_n = 1'b0;
    enable  = 1'b0;
    drive('0);
    repeat (3) tick();
    reset_values("rst");
    reset_n = 1'b1;
    repeat (4) tick();
    check("idle_after_rst", 32'(busy8), 0);

    // spikes[3] once every 8 cycles
    for (int t = 0; t < WINDOW; t++) win_pat[t] = (t % 8 == 0) ? 7'b0001000 : 7'b0000000;
    run_window(1'b0, 1'b0);
    check("s1_idx", 32'(w_idx8), 3);
    check("s1_cnt", 32'(w_cnt8), 8);
    check("s1_mask", 32'(mask8), 32'h08);

    // identical patterns on 1 and 5: tie goes to 1
    for (int t = 0; t < WINDOW; t++) win_pat[t] = (t % 16 == 2) ? 7'b0100010 : 7'b0000000;
    run_window(1'b0, 1'b0);
    check("s2_idx", 32'(w_idx8), 1);
    check("s2_cnt", 32'(w_cnt8), 4);
    check("s2_mask", 32'(mask8), 32'h22);

    // silent window
    for (int t = 0; t < WINDOW; t++) win_pat[t] = 7'b0000000;
    run_window(1'b0, 1'b0);
    check("s3_idx", 32'(w_idx8), 7);
    check("s3_cnt", 32'(w_cnt8), 0);

    // spikes[0] rises at cycle 0 and stays high
    for (int t = 0; t < WINDOW; t++) win_pat[t] = 7'b0000001;
    run_window(1'b0, 1'b0);
    check("s4_idx", 32'(w_idx8), 0);
    check("s4_cnt", 32'(w_cnt8), 1);
    check("s4_mask", 32'(mask8), 0);

    // 20 edges on spikes[6]: saturates in the 4-bit instance
    for (int t = 0; t < WINDOW; t++) win_pat[t] = (t % 3 == 0 && t < 60) ? 7'b1000000 : 7'b0000000;
    run_window(1'b0, 1'b0);
    check("s5_cnt8", 32'(w_cnt8), 20);
    check("s5_cnt4", 32'(w_cnt4), 15);
    check("s5_idx4", 32'(w_idx4), 6);

    // aborts in COUNT and in ARGMAX
    abort_window(30);
    abort_window(WINDOW + 2);

    // back-to-back windows
    fill_random();
    run_window(1'b0, 1'b1);
    fill_random();
    run_window(1'b1, 1'b0);

    // reset pulse mid-window
    enable = 1'b1;
    drive('0);
    tick();
    for (int c = 0; c < 20; c++) begin
      drive((c % 2 == 0) ? 7'b0000100 : 7'b0000000);
      tick();
    end
    reset_n = 1'b0;
    #1;
    reset_values("mid_rst");
    enable = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("idle_after_mid_rst", 32'(busy8), 0);
    for (int t = 0; t < WINDOW; t++) win_pat[t] = 7'b0000001;
    run_window(1'b0, 1'b0);

    // randomized windows, randomly chained
    chain = 1'b0;
    for (int w = 0; w < 14; w++) begin
      bit nxt;
      nxt = (w == 13) ? 1'b0 : 1'($urandom_range(0, 1));
      fill_random();
      run_window(chain, nxt);
      chain = nxt;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 Parameter N, default 7: number of neurons and spike input bits.
REQ-002 Parameter WINDOW, default 64: counting window length in clk cycles; legal range 2..65535.
REQ-003 Parameter CNT_W, default 8: width of each per-neuron spike counter.
REQ-004 Parameter THRESH, default 2: minimum count for a neuron to be flagged in active_mask.
REQ-005 clk  input  1: single clock; all state changes on the rising edge.
REQ-006 reset_n  input  1: asynchronous, active-low reset.
REQ-007 enable  input  1: level; 1 runs decoding windows, 0 aborts or holds the block idle.
REQ-008 spikes  input  N: held spike levels from the upstream Hopfield network.
REQ-009 winner_idx  output  3: index of the neuron with the highest count; 7 means no winner.
REQ-010 winner_count  output  CNT_W: count of the winning neuron.
REQ-011 active_mask  output  N: bit i = 1 when count[i] >= THRESH.
REQ-012 result_valid  output  1: one-cycle pulse when the outputs above are updated.
REQ-013 busy  output  1: 1 whenever the state is not IDLE.

Function
REQ-014 A spike event for neuron i is a rising edge: spikes[i]=1 while prev[i]=0; prev updates to spikes every cycle in every state.
REQ-015 States are IDLE, COUNT, ARGMAX and REPORT.
REQ-016 IDLE -> COUNT on the cycle after enable=1 is sampled; all counters and the window counter clear on entry to COUNT.
REQ-017 COUNT: each spike event increments its neuron's counter, which saturates at 2^CNT_W-1; edges in IDLE, ARGMAX and REPORT are ignored.
REQ-018 COUNT lasts exactly WINDOW cycles (window counter 0..WINDOW-1), then moves to ARGMAX.
REQ-019 ARGMAX scans neurons 0..N-1, one per cycle (N cycles), with a strict greater-than compare, so ties resolve to the lowest index.
REQ-020 If every count is 0 at the end of the scan, the winner is winner_idx=7 with winner_count=0.
REQ-021 REPORT lasts one cycle: winner_idx, winner_count and active_mask register and result_valid=1; next state is COUNT if enable=1, else IDLE.
REQ-022 Result latency is WINDOW+N+1 cycles from COUNT entry to the result_valid cycle; back-to-back windows have no gap beyond ARGMAX and REPORT.
REQ-023 enable=0 in COUNT or ARGMAX aborts to IDLE on the next edge: no result_valid, counters are discarded and the previous outputs are held.
REQ-024 enable=0 during REPORT still completes the report, then goes to IDLE.
REQ-025 Outputs hold their values between reports.
REQ-026 Counters and compares are unsigned; no signed arithmetic is used.

Reset
REQ-027 Asserting reset_n=0 at any time, including mid-window, immediately forces: state IDLE; counters, window counter and prev cleared; winner_idx=7; winner_count=0; active_mask=0; result_valid=0; busy=0.
REQ-028 After reset_n deasserts, the first window starts only via REQ-016.

Structure
REQ-029 Shared package hopfield_pkg holds N, the state encoding and the NO_WINNER=3'd7 constant; the upstream network uses the same N.
REQ-030 One sub-module, spike_edge_counter, is instantiated N times: edge detect plus a saturating CNT_W counter with clear and count-enable inputs.
REQ-031 ARGMAX is sequential with a single comparator; no N-way combinational max tree.

Verification (defaults N=7, WINDOW=64, THRESH=2)
REQ-032 Bench shall cover: enable=1, spikes[3] high 1 of every 8 cycles, others 0 -> result_valid 72 cycles after COUNT entry; winner_idx=3, winner_count=8, active_mask=7'b0001000.
REQ-033 Bench shall cover: spikes[1] and spikes[5] with identical 4-edge patterns -> winner_idx=1, winner_count=4, active_mask=7'b0100010.
REQ-034 Bench shall cover: spikes all 0 for a full window -> winner_idx=7, winner_count=0, active_mask=0, result_valid pulsed once.
REQ-035 Bench shall cover: spikes[0] rising at cycle 0 and held high all window -> winner_idx=0, winner_count=1, active_mask=0.
REQ-036 Bench shall cover: enable dropped at COUNT cycle 30 -> no result_valid, busy=0 next cycle, prior outputs unchanged.
REQ-037 Bench shall cover: CNT_W=4 with 20 edges on spikes[6] -> winner_count=15, and reset_n pulsed mid-window -> all outputs at reset values.
